// File: rtl/alu_mult_sequencer_if.sv
// rtl/alu_mult_sequencer_if.sv - issue handshake and ALU operand bus for the shift-add multiplier
interface alu_mult_sequencer_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic [63:0] product;
  logic        busy;
  logic        done;

  modport master (
    output start, multiplicand, multiplier, alu_result, alu_cout,
    input  alu_A, alu_B, alu_op, alu_cin, product, busy, done
  );

  modport slave (
    input  start, multiplicand, multiplier, alu_result, alu_cout,
    output alu_A, alu_B, alu_op, alu_cin, product, busy, done
  );
endinterface

// File: rtl/alu_mult_sequencer.sv
// rtl/alu_mult_sequencer.sv - shift-add 32x32->64 unsigned multiplier sequencer
// Borrows the shared 32-bit ALU as its adder; one ADD/SHIFT pair per multiplier bit.
module alu_mult_sequencer #(
  parameter logic [2:0] OP_ADD  = 3'b010,
  parameter logic [2:0] OP_IDLE = 3'b000,
  parameter int         N_ITER  = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_mult_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'(N_ITER - 1);

  state_t      state;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mcand;
  logic        c;
  logic [4:0]  count;
  logic        busy_q;
  logic        done_q;
  logic [2:0]  op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      c      <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q   <= OP_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            hi     <= '0;
            lo     <= bus.multiplier;
            mcand  <= bus.multiplicand;
            c      <= 1'b0;
            count  <= '0;
            busy_q <= 1'b1;
            op_q   <= OP_ADD;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (lo[0]) begin
            {c, hi} <= {bus.alu_cout, bus.alu_result};
          end else begin
            c <= 1'b0;
          end
          op_q  <= OP_IDLE;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // 65-bit logical right shift of {c,hi,lo}
          c     <= 1'b0;
          hi    <= {c, hi[31:1]};
          lo    <= {hi[0], lo[31:1]};
          count <= count + 5'd1;
          if (count == LAST_ITER) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            op_q  <= OP_ADD;
            state <= S_ADD;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          op_q   <= OP_IDLE;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.alu_A   = (state == S_ADD) ? hi : 32'd0;
  assign bus.alu_B   = (state == S_ADD) ? mcand : 32'd0;
  assign bus.alu_op  = op_q;
  assign bus.alu_cin = 1'b0;
  assign bus.product = {hi, lo};
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Control unit for an unsigned 32x32 -> 64-bit shift-add multiplier. It reuses the team's shared 32-bit ALU as its only adder.
- Owns the multiplicand, product and iteration-count registers. It drives the ALU operands and opcode, and captures the ALU sum/carry once per iteration.
- Sits beside the 32-bit ALU in the processor datapath. Exposes a start/busy/done handshake to the issuing logic.

Parameters:
- OP_ADD, 3'b010, ALU opcode selecting 32-bit add.
- OP_IDLE, 3'b000, ALU opcode driven when not multiplying (AND).
- N_ITER, 32, iteration count; fixed at 32, other values unsupported.

Ports:
- clk  input  1  single clock; all registers on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  32  operand A; latched on accepted start.
- multiplier  input  32  operand B; latched on accepted start.
- alu_A  output  32  ALU operand A.
- alu_B  output  32  ALU operand B.
- alu_op  output  3  ALU opcode.
- alu_cin  output  1  ALU carry-in; constant 0.
- alu_result  input  32  ALU sum; combinational from alu_A/alu_B/alu_op.
- alu_cout  input  1  ALU carry-out for the same operation.
- product  output  64  result register {hi,lo}.
- busy  output  1  high in ADD and SHIFT states.
- done  output  1  one-cycle pulse in DONE state.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - product, multiplicand register, count and carry register = 0.
  - done=0, busy=0.
  - Reset mid-operation aborts the multiply with no partial result retained.
- Registers: hi[31:0]=product[63:32], lo[31:0]=product[31:0], mcand[31:0], c (1 bit), count[4:0].
- IDLE:
  - alu_A=0, alu_B=0, alu_op=OP_IDLE.
  - If start=1 at the edge: hi<=0, lo<=multiplier, mcand<=multiplicand, c<=0, count<=0, go to ADD.
  - Otherwise product holds its last value.
- ADD:
  - alu_A=hi, alu_B=mcand, alu_op=OP_ADD, busy=1.
  - At the edge: if lo[0]=1, {c,hi}<={alu_cout,alu_result}; else c<=0 and hi is unchanged.
  - Always go to SHIFT.
- SHIFT:
  - busy=1, alu_op=OP_IDLE.
  - At the edge: {c,hi,lo}<={1'b0,c,hi,lo}>>1 (logical, 65-bit).
  - count<=count+1.
  - If count==31 before the increment, go to DONE; otherwise go to ADD.
  - count wraps to 0 on the final increment and is unused afterwards.
- DONE:
  - done=1, busy=0, product stable; go to IDLE.
  - start is ignored in DONE; it must be reasserted in IDLE.
- Latency:
  - Accepted start at edge E0; the first ADD cycle follows.
  - 64 busy cycles (32 ADD/SHIFT pairs); done is high in cycle 65 after E0.
  - product is valid from the DONE cycle and held until the next accepted start.
- start while busy or in DONE: ignored. Operand inputs may change freely after acceptance.
- Arithmetic: unsigned only. The full 64-bit product is exact; no overflow flag.
- alu_cin is 0 in all states.
- Outputs depend only on state and registers; no combinational path from start to any output.

Test Plan:
- Bench: drive alu_result/alu_cout from the team's 32-bit ALU (or an equivalent behavioural adder on OP_ADD).
- rst_n low, then high; no start -> product=0, busy=0, done=0, alu_op=000 for 10 cycles.
- multiplicand=3, multiplier=5, pulse start -> busy for exactly 64 cycles; done pulse in cycle 65; product=64'h0000_0000_0000_000F, held afterwards.
- 0xFFFFFFFF x 0xFFFFFFFF -> product=64'hFFFF_FFFE_0000_0001. Checks carry capture on every iteration.
- multiplicand=0x12345678, multiplier=0 -> product=0; ALU is driven but hi is never written. Then 0x0 x 0xDEADBEEF -> product=0.
- Start 7x9, pulse start with 2x2 at busy cycle 10 -> ignored; product=63. A start held high through DONE -> new operation begins only from IDLE (done-to-next-busy gap of 1 IDLE cycle).
- Start 0x10000 x 0x10000, assert rst_n=0 at busy cycle 20 -> asynchronous clear of product, busy and done mid-cycle. After release, 6x7 -> product=42.
